wave_generator: RTL and testbench

WAVE_GENERATOR -- requirements
Module: wave_generator

---
 rtl/wave_gen_pkg.sv | 31 +++
 rtl/wave_generator_sine_lut.sv | 34 +++
 rtl/wave_generator.sv | 118 +++++++++++
 tb/tb_wave_generator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
// Shared definitions for the wave generator: shape select codes, FSM state
// encoding, midscale level, default accumulator width and shape helpers.
package wave_gen_pkg;

  localparam int         ACC_W_DEF = 16;
  localparam logic [7:0] MIDSCALE  = 8'd128;

  typedef enum logic [1:0] {
    SAW = 2'd0,
    TRI = 2'd1,
    SQR = 2'd2,
    SIN = 2'd3
  } wave_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // Triangle: rising 0..254 over the first half, falling 254..0 over the second.
  function automatic logic [7:0] tri_shape(input logic [7:0] p);
    return p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
  endfunction

  // Square: high for the first half period, low for the second.
  function automatic logic [7:0] sqr_shape(input logic [7:0] p);
    return p[7] ? 8'd0 : 8'd255;
  endfunction

endpackage

// File: rtl/wave_generator_sine_lut.sv
// Quarter-wave sine magnitude table: o_mag = round(127*sin(2*pi*i_idx/256)).
// Only compiled when WAVE_SINE_LUT_EN is defined.
`ifdef WAVE_SINE_LUT_EN
module sine_quarter_lut (
  input  logic [5:0] i_idx,
  output logic [6:0] o_mag
);

  // Combinational table lookup over the first quarter period.
  always_comb begin
    o_mag = 7'd0;
    case (i_idx)
      6'd0:  o_mag = 7'd0;   6'd1:  o_mag = 7'd3;   6'd2:  o_mag = 7'd6;   6'd3:  o_mag = 7'd9;
      6'd4:  o_mag = 7'd12;  6'd5:  o_mag = 7'd16;  6'd6:  o_mag = 7'd19;  6'd7:  o_mag = 7'd22;
      6'd8:  o_mag = 7'd25;  6'd9:  o_mag = 7'd28;  6'd10: o_mag = 7'd31;  6'd11: o_mag = 7'd34;
      6'd12: o_mag = 7'd37;  6'd13: o_mag = 7'd40;  6'd14: o_mag = 7'd43;  6'd15: o_mag = 7'd46;
      6'd16: o_mag = 7'd49;  6'd17: o_mag = 7'd51;  6'd18: o_mag = 7'd54;  6'd19: o_mag = 7'd57;
      6'd20: o_mag = 7'd60;  6'd21: o_mag = 7'd63;  6'd22: o_mag = 7'd65;  6'd23: o_mag = 7'd68;
      6'd24: o_mag = 7'd71;  6'd25: o_mag = 7'd73;  6'd26: o_mag = 7'd76;  6'd27: o_mag = 7'd78;
      6'd28: o_mag = 7'd81;  6'd29: o_mag = 7'd83;  6'd30: o_mag = 7'd85;  6'd31: o_mag = 7'd88;
      6'd32: o_mag = 7'd90;  6'd33: o_mag = 7'd92;  6'd34: o_mag = 7'd94;  6'd35: o_mag = 7'd96;
      6'd36: o_mag = 7'd98;  6'd37: o_mag = 7'd100; 6'd38: o_mag = 7'd102; 6'd39: o_mag = 7'd104;
      6'd40: o_mag = 7'd106; 6'd41: o_mag = 7'd107; 6'd42: o_mag = 7'd109; 6'd43: o_mag = 7'd111;
      6'd44: o_mag = 7'd112; 6'd45: o_mag = 7'd113; 6'd46: o_mag = 7'd115; 6'd47: o_mag = 7'd116;
      6'd48: o_mag = 7'd117; 6'd49: o_mag = 7'd118; 6'd50: o_mag = 7'd120; 6'd51: o_mag = 7'd121;
      6'd52: o_mag = 7'd122; 6'd53: o_mag = 7'd122; 6'd54: o_mag = 7'd123; 6'd55: o_mag = 7'd124;
      6'd56: o_mag = 7'd125; 6'd57: o_mag = 7'd125; 6'd58: o_mag = 7'd126; 6'd59: o_mag = 7'd126;
      6'd60: o_mag = 7'd126; 6'd61: o_mag = 7'd127; 6'd62: o_mag = 7'd127; 6'd63: o_mag = 7'd127;
      default: o_mag = 7'd0;
    endcase
  end

endmodule
`endif

// File: rtl/wave_generator.sv
// Phase-accumulator waveform generator (saw / triangle / square / sine).
// Frequency and shape are only re-latched on a phase wrap so switching is
// glitch-free. Define WAVE_SINE_LUT_EN to build the sine table; without it,
// shape select 3 falls back to the triangle.
module wave_generator
  import wave_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic [1:0]       wave_sel,
  input  logic [ACC_W-1:0] freq_word,
  output logic [7:0]       wave,
  output logic             sync,
  output logic             busy
);

  state_e           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  wave_sel_e        r_sel;

  logic [ACC_W:0]   w_sum;
  logic             w_wrap;
  logic [7:0]       w_p;
  logic [7:0]       w_tri;
  logic [7:0]       w_shape;

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_wrap = w_sum[ACC_W];
  assign w_p    = r_acc[ACC_W-1:ACC_W-8];
  assign w_tri  = tri_shape(w_p);
  assign busy   = (r_state != ST_IDLE);

`ifdef WAVE_SINE_LUT_EN
  logic [5:0] w_lidx;
  logic [6:0] w_mag;
  logic [6:0] w_mag_adj;
  logic [7:0] w_sin;

  // Fold the phase into the first quarter: odd quarters mirror (64-k, with the
  // k=0 peak handled explicitly), the second half inverts around midscale.
  always_comb begin
    w_lidx    = w_p[6] ? (6'd0 - w_p[5:0]) : w_p[5:0];
    w_mag_adj = (w_p[6] && (w_p[5:0] == 6'd0)) ? 7'd127 : w_mag;
    w_sin     = w_p[7] ? (MIDSCALE - {1'b0, w_mag_adj}) : (MIDSCALE + {1'b0, w_mag_adj});
  end

  sine_quarter_lut u_sine_lut (
    .i_idx (w_lidx),
    .o_mag (w_mag)
  );
`endif

  // Select the sample shape from the pre-update phase.
  always_comb begin
    w_shape = w_p;
    case (r_sel)
      SAW:     w_shape = w_p;
      TRI:     w_shape = w_tri;
      SQR:     w_shape = sqr_shape(w_p);
`ifdef WAVE_SINE_LUT_EN
      SIN:     w_shape = w_sin;
`else
      SIN:     w_shape = w_tri;
`endif
      default: w_shape = w_p;
    endcase
  end

  // Control FSM with accumulator and registered wave/sync outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_inc   <= '0;
      r_sel   <= SAW;
      wave    <= MIDSCALE;
      sync    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          wave <= MIDSCALE;
          sync <= 1'b0;
          if (en) begin
            r_state <= ST_RUN;
            r_acc   <= '0;
            r_inc   <= freq_word;
            r_sel   <= wave_sel_e'(wave_sel);
          end
        end
        ST_RUN, ST_STOPPING: begin
          r_acc <= w_sum[ACC_W-1:0];
          wave  <= w_shape;
          sync  <= w_wrap;
          if (w_wrap) begin
            r_inc <= freq_word;
            r_sel <= wave_sel_e'(wave_sel);
          end
          if (r_state == ST_RUN) begin
            if (!en) r_state <= ST_STOPPING;
          end else if (en) begin
            // Resume without clearing the phase.
            r_state <= ST_RUN;
          end else if (w_wrap || (r_inc == '0)) begin
            // Finish the period (or bail out if the phase can never wrap).
            r_state <= ST_IDLE;
            wave    <= MIDSCALE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// Directed bench for wave_generator: a behavioural model compared every
// cycle plus hand-computed literal checks. Honours WAVE_SINE_LUT_EN.
module tb_wave_generator;

  logic        clk = 1'b0;
  logic        rst_;
  logic        en;
  logic [1:0]  wave_sel;
  logic [15:0] freq_word;
  logic [7:0]  wave;
  logic        sync;
  logic        busy;

  int n_pass = 0;
  int n_tot  = 0;
  int ek     = 0;

  // model state
  int m_mode = 0;  // 0 idle, 1 running, 2 stopping
  int m_acc  = 0;
  int m_inc  = 0;
  int m_sel  = 0;
  int m_wave = 128;
  int m_sync = 0;

  wave_generator dut (
    .clk       (clk),
    .rst_      (rst_),
    .en        (en),
    .wave_sel  (wave_sel),
    .freq_word (freq_word),
    .wave      (wave),
    .sync      (sync),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int shape(input int sel, input int p);
    int t;
    t = (p < 128) ? 2 * p : 2 * (255 - p);
    case (sel)
      0: return p;
      1: return t;
      2: return (p < 128) ? 255 : 0;
      default: begin
`ifdef WAVE_SINE_LUT_EN
        real s;
        s = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0);
        return int'($floor(s + 0.5));
`else
        return t;
`endif
      end
    endcase
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s (edge %0d): got %0d expected %0d", nm, ek, got, exp);
  endtask

  // Behavioural model: one period step per clock from the stated rules.
  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_mode = 0; m_acc = 0; m_inc = 0; m_sel = 0; m_wave = 128; m_sync = 0;
    end else if (m_mode == 0) begin
      m_wave = 128; m_sync = 0;
      if (en) begin
        m_mode = 1; m_acc = 0; m_inc = int'(freq_word); m_sel = int'(wave_sel);
      end
    end else begin
      int sum, old_inc;
      old_inc = m_inc;
      sum     = m_acc + m_inc;
      m_wave  = shape(m_sel, m_acc / 256);
      m_sync  = (sum >= 65536) ? 1 : 0;
      m_acc   = sum % 65536;
      if (m_sync == 1) begin
        m_inc = int'(freq_word); m_sel = int'(wave_sel);
      end
      if (m_mode == 1) begin
        if (!en) m_mode = 2;
      end else if (en) begin
        m_mode = 1;
      end else if (m_sync == 1 || old_inc == 0) begin
        m_mode = 0; m_wave = 128;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_) begin
      chk("model_wave", int'(wave), m_wave);
      chk("model_sync", int'(sync), m_sync);
      chk("model_busy", int'(busy), (m_mode != 0) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); ek++; end
  endtask

  task automatic to_edge(input int k);
    tick(k - ek);
  endtask

  // Called at a falling edge: pulse reset, then request a run; next rising edge is E0.
  task automatic restart(input int sel, input int fw);
    rst_ = 1'b0; #1; rst_ = 1'b1;
    wave_sel = 2'(sel); freq_word = 16'(fw); en = 1'b1; ek = -1;
  endtask

  task automatic chk3(input string nm, input int w, input int s, input int b);
    chk({nm, "_wave"}, int'(wave), w);
    chk({nm, "_sync"}, int'(sync), s);
    chk({nm, "_busy"}, int'(busy), b);
  endtask

  initial begin
    rst_ = 1'b0; en = 1'b0; wave_sel = 2'd0; freq_word = 16'd0;
    @(negedge clk);
    chk3("reset", 128, 0, 0);
    rst_ = 1'b1;
    tick(3);
    chk3("idle_no_en", 128, 0, 0);

    // saw, 0x0100
    @(negedge clk); restart(0, 16'h0100);
    tick(1);         chk3("saw_e0", 128, 0, 1);
    to_edge(1);      chk("saw_e1", int'(wave), 0);
    to_edge(5);      chk("saw_e5", int'(wave), 4);
    to_edge(255);    chk3("saw_e255", 254, 0, 1);
    to_edge(256);    chk3("saw_wrap", 255, 1, 1);
    to_edge(257);    chk3("saw_e257", 0, 0, 1);
    to_edge(512);    chk("saw_wrap2", int'(sync), 1);

    // triangle
    @(negedge clk); restart(1, 16'h0100);
    to_edge(2);      chk("tri_e2", int'(wave), 2);
    to_edge(128);    chk("tri_e128", int'(wave), 254);
    to_edge(129);    chk("tri_e129", int'(wave), 254);
    to_edge(130);    chk("tri_e130", int'(wave), 252);
    to_edge(256);    chk3("tri_end", 0, 1, 1);

    // square
    @(negedge clk); restart(2, 16'h0100);
    to_edge(1);      chk("sqr_e1", int'(wave), 255);
    to_edge(128);    chk("sqr_e128", int'(wave), 255);
    to_edge(129);    chk("sqr_e129", int'(wave), 0);
    to_edge(256);    chk3("sqr_end", 0, 1, 1);

    // select 3 at quarter-period steps
    @(negedge clk); restart(3, 16'h4000);
`ifdef WAVE_SINE_LUT_EN
    to_edge(1); chk("sin_p0", int'(wave), 128);
    to_edge(2); chk("sin_p64", int'(wave), 255);
    to_edge(3); chk("sin_p128", int'(wave), 128);
    to_edge(4); chk("sin_p192", int'(wave), 1);
`else
    to_edge(1); chk("sel3_p0", int'(wave), 0);
    to_edge(2); chk("sel3_p64", int'(wave), 128);
    to_edge(3); chk("sel3_p128", int'(wave), 254);
    to_edge(4); chk("sel3_p192", int'(wave), 126);
`endif
    chk("sel3_sync", int'(sync), 1);

    // frequency change mid-period takes effect at the wrap
    @(negedge clk); restart(0, 16'h0100);
    to_edge(10);     freq_word = 16'h0200;
    to_edge(21);     chk("fchg_e21", int'(wave), 20);
    to_edge(256);    chk3("fchg_wrap", 255, 1, 1);
    to_edge(258);    chk("fchg_e258", int'(wave), 2);
    to_edge(259);    chk("fchg_e259", int'(wave), 4);
    to_edge(384);    chk("fchg_wrap2", int'(sync), 1);

    // en dropped at phase 100, finishes the period
    @(negedge clk); restart(0, 16'h0100);
    to_edge(100);    en = 1'b0;
    to_edge(101);    chk3("stop_e101", 100, 0, 1);
    to_edge(255);    chk3("stop_e255", 254, 0, 1);
    to_edge(256);    chk3("stop_wrap", 128, 1, 0);
    to_edge(258);    chk3("stop_idle", 128, 0, 0);

    // en re-raised during stopping continues the phase
    @(negedge clk); restart(0, 16'h0100);
    to_edge(100);    en = 1'b0;
    to_edge(150);    en = 1'b1;
    to_edge(160);    chk3("resume_e160", 159, 0, 1);
    to_edge(256);    chk3("resume_wrap", 255, 1, 1);

    // asynchronous reset mid-run
    #2; rst_ = 1'b0; #1;
    chk3("async_rst", 128, 0, 0);

    // zero increment: static output, then idle one clock after stopping
    @(negedge clk); restart(0, 16'h0000);
    to_edge(1);      chk3("zinc_e1", 0, 0, 1);
    to_edge(5);      chk3("zinc_e5", 0, 0, 1);
    en = 1'b0;
    to_edge(6);      chk("zinc_stop_busy", int'(busy), 1);
    to_edge(7);      chk3("zinc_idle", 128, 0, 0);

    // wrap and en low on the same edge still latch new settings
    @(negedge clk); restart(0, 16'h0100);
    to_edge(255);    freq_word = 16'h8000; wave_sel = 2'd2; en = 1'b0;
    to_edge(256);    chk3("wrapstop_e256", 255, 1, 1);
    to_edge(257);    chk3("wrapstop_e257", 255, 0, 1);
    to_edge(258);    chk3("wrapstop_e258", 128, 1, 0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
